// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command encodings and arbiter state codes
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_MRS     = 4'b0000;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_ACT     = 4'b0011;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_ARBIT = 2'd1;
    localparam logic [1:0] ST_AREF  = 2'd2;
    localparam logic [1:0] ST_CHAN  = 2'd3;

    // Index width that stays at least one bit when only one channel exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - SDRAM pin-side bundle driven by the arbiter
interface sdram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int BANK_W = 2,
    parameter int DATA_W = 16
);
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BANK_W-1:0] sdram_bank;
    logic [DATA_W-1:0] dq_out;
    logic              dq_oe;

    modport master (
        output sdram_cmd, sdram_addr, sdram_bank, dq_out, dq_oe
    );

    modport slave (
        input sdram_cmd, sdram_addr, sdram_bank, dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_rr_pick.sv
// rtl/sdram_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module sdram_rr_pick #(
    parameter int NCH = 2,
    parameter int IW  = 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic           valid,
    output logic [IW-1:0]  idx
);
    // Two passes avoid a modulo index: upper segment [ptr..NCH-1], then wrap [0..ptr-1].
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!valid && req[i] && (IW'(i) >= ptr)) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!valid && req[i] && (IW'(i) < ptr)) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - init/refresh/channel arbiter and SDRAM command multiplexer
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 12,
    parameter int BANK_W  = 2,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024,
    localparam int GW     = idx_w(NCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_done,
    input  logic [3:0]            init_cmd,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic                  ref_req,
    output logic                  ref_en,
    input  logic                  ref_end,
    input  logic [3:0]            ref_cmd,
    input  logic [ADDR_W-1:0]     ref_addr,
    input  logic [NCH-1:0]        ch_req,
    output logic [NCH-1:0]        ch_en,
    input  logic [NCH-1:0]        ch_end,
    input  logic [4*NCH-1:0]      ch_cmd,
    input  logic [ADDR_W*NCH-1:0] ch_addr,
    input  logic [BANK_W*NCH-1:0] ch_bank,
    input  logic [NCH-1:0]        ch_oe,
    input  logic [DATA_W*NCH-1:0] ch_wdata,
    sdram_arbiter_if.master       pins,
    output logic [GW-1:0]         grant_id,
    output logic                  timeout_err
);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]        state;
    logic [GW-1:0]     rr_ptr;
    logic [WW-1:0]     wd;
    logic              pick_valid;
    logic [GW-1:0]     pick_idx;
    logic [NCH-1:0]    pick_oh;
    logic              sel_end;
    logic              sel_oe;
    logic [3:0]        sel_cmd;
    logic [ADDR_W-1:0] sel_addr;
    logic [BANK_W-1:0] sel_bank;
    logic [DATA_W-1:0] sel_wdata;
    logic              wd_fire;
    logic [GW-1:0]     next_ptr;

    sdram_rr_pick #(.NCH(NCH), .IW(GW)) u_pick (
        .req   (ch_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_oh   = '0;
        sel_end   = 1'b0;
        sel_oe    = 1'b0;
        sel_cmd   = CMD_NOP;
        sel_addr  = '0;
        sel_bank  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            pick_oh[i] = (pick_idx == GW'(i));
            if (grant_id == GW'(i)) begin
                sel_end   = ch_end[i];
                sel_oe    = ch_oe[i];
                sel_cmd   = ch_cmd[4*i +: 4];
                sel_addr  = ch_addr[ADDR_W*i +: ADDR_W];
                sel_bank  = ch_bank[BANK_W*i +: BANK_W];
                sel_wdata = ch_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign next_ptr    = (grant_id == GW'(NCH - 1)) ? '0 : grant_id + GW'(1);
    assign wd_fire     = (TIMEOUT != 0) && (state == ST_CHAN) && (wd == WW'(TIMEOUT - 1));
    // A completion arriving on the expiry cycle counts as a normal end, not an error.
    assign timeout_err = wd_fire && !sel_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            rr_ptr   <= '0;
            grant_id <= '0;
            wd       <= '0;
            ref_en   <= 1'b0;
            ch_en    <= '0;
        end else begin
            ref_en <= 1'b0;
            ch_en  <= '0;
            case (state)
                ST_INIT: begin
                    if (init_done) state <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (ref_req) begin
                        state  <= ST_AREF;
                        ref_en <= 1'b1;
                    end else if (pick_valid) begin
                        state    <= ST_CHAN;
                        ch_en    <= pick_oh;
                        grant_id <= pick_idx;
                        wd       <= '0;
                    end
                end
                ST_AREF: begin
                    if (ref_end) state <= ST_ARBIT;
                end
                ST_CHAN: begin
                    if (sel_end || wd_fire) begin
                        state  <= ST_ARBIT;
                        rr_ptr <= next_ptr;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        pins.sdram_cmd  = CMD_NOP;
        pins.sdram_addr = '0;
        pins.sdram_bank = '0;
        case (state)
            ST_INIT: begin
                pins.sdram_cmd  = init_cmd;
                pins.sdram_addr = init_addr;
            end
            ST_AREF: begin
                pins.sdram_cmd  = ref_cmd;
                pins.sdram_addr = ref_addr;
            end
            ST_CHAN: begin
                pins.sdram_cmd  = sel_cmd;
                pins.sdram_addr = sel_addr;
                pins.sdram_bank = sel_bank;
            end
            default: ;
        endcase
        pins.dq_oe  = (state == ST_CHAN) && sel_oe;
        pins.dq_out = pins.dq_oe ? sel_wdata : '0;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Parametrised arbiter and command multiplexer for the SDRAM controller. It sits between the init, auto-refresh and NCH data-channel engines (write, read, …) and the SDRAM pins. It grants exactly one owner at a time: init first, then refresh with strict priority, then data channels in round-robin order. A watchdog recovers from a channel that never signals completion.

## Interface
- NCH, 2: number of data channels (≥1); channel 0 is conventionally write, channel 1 read
- ADDR_W, 12: SDRAM address width
- BANK_W, 2: bank address width
- DATA_W, 16: DQ width
- TIMEOUT, 1024: max cycles a data channel may hold the bus; 0 disables the watchdog
- Clocking: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_done  in  1  init engine finished; level, sampled only in INIT
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from the init engine
- init_addr  in  ADDR_W  address from the init engine
- ref_req  in  1  refresh request (level)
- ref_en  out  1  one-cycle refresh grant pulse
- ref_end  in  1  refresh sequence complete pulse
- ref_cmd  in  4  refresh engine command
- ref_addr  in  ADDR_W  refresh engine address
- ch_req  in  NCH  per-channel request (level)
- ch_en  out  NCH  one-hot, one-cycle grant pulse
- ch_end  in  NCH  per-channel completion pulse
- ch_cmd  in  4*NCH  flattened channel commands; channel i is at [4i+3:4i]
- ch_addr  in  ADDR_W*NCH  flattened channel addresses
- ch_bank  in  BANK_W*NCH  flattened channel bank addresses
- ch_oe  in  NCH  channel drives DQ this cycle
- ch_wdata  in  DATA_W*NCH  flattened write data
- sdram_cmd  out  4  muxed command to pins
- sdram_addr  out  ADDR_W  muxed address
- sdram_bank  out  BANK_W  muxed bank
- dq_out  out  DATA_W  DQ output value
- dq_oe  out  1  DQ tristate enable (1 = drive)
- grant_id  out  $clog2(NCH)  index of the current or last channel owner
- timeout_err  out  1  one-cycle pulse when the watchdog fires

## Operation
- States: INIT, ARBIT, AREF, CHAN.
- INIT→ARBIT when init_done=1.
- In ARBIT, refresh has strict priority:
  - If ref_req=1, go to AREF and pulse ref_en.
  - Otherwise, if any ch_req is set, go to CHAN. The round-robin picker selects the first requesting channel at or after rr_ptr. Pulse ch_en[g] and load grant_id=g.
- AREF→ARBIT on ref_end.
- CHAN→ARBIT on ch_end[grant_id], or on watchdog expiry. In either case rr_ptr←(grant_id+1) mod NCH.
- Output mux is combinational from state:
  - INIT: init_cmd/init_addr, bank 0.
  - AREF: ref_cmd/ref_addr, bank 0.
  - CHAN: the granted channel's cmd/addr/bank.
  - ARBIT: NOP 4'b0111, addr 0, bank 0.
- DQ:
  - dq_oe = (state==CHAN) & ch_oe[grant_id].
  - dq_out = granted channel's ch_wdata when dq_oe=1, else 0.
- Ignored inputs:
  - ch_end from a non-granted channel.
  - ref_end outside AREF.
  - ch_end outside CHAN.
  - init_done after leaving INIT.
- Watchdog:
  - The counter clears on entry to CHAN and increments each CHAN cycle.
  - When it reaches TIMEOUT-1 without ch_end: pulse timeout_err, return to ARBIT, advance rr_ptr.

## Timing
- Reset values:
  - state=INIT, rr_ptr=0, grant_id=0, watchdog=0.
  - ref_en=0, ch_en=0, timeout_err=0, dq_oe=0, dq_out=0, sdram_bank=0.
  - sdram_cmd/sdram_addr follow init_cmd/init_addr.
- Reset asserted mid-operation returns to INIT immediately (asynchronous); pins revert to the init mux.
- Grant latency:
  - The request is sampled at the rising edge ending an ARBIT cycle.
  - On that same edge, state changes and ref_en/ch_en go high for exactly one cycle, the first cycle of AREF/CHAN.
  - The owner's command appears on the pins in that same cycle.
- Release: an end pulse in cycle t puts ARBIT (NOP) on the pins in cycle t+1. ARBIT lasts at least one cycle between owners.
- Simultaneous ref_req and ch_req in ARBIT: refresh wins. The channel stays pending and is granted after ref_end with rr_ptr unchanged.
- ref_req rising during CHAN does not preempt; it is serviced at the next ARBIT.
- NCH=1: rr_ptr is constant 0 and grant_id width is 1.

## Structure
- Package sdram_pkg holds:
  - CMD_NOP=4'b0111 and the other command encodings.
  - The state enum/localparams INIT, ARBIT, AREF, CHAN.
- Sub-module sdram_rr_pick: combinational round-robin picker. Inputs are req[NCH] and ptr; outputs are valid and idx.
- The top holds the FSM, rr_ptr, watchdog and the output mux.

## Test plan
- Reset then init_done=1 at cycle 10 → pins show init_cmd through cycle 10, then NOP 0111 in ARBIT.
- ref_req=1 and ch_req=2'b11 together in ARBIT → ref_en pulses for 1 cycle, pins show ref_cmd. After ref_end, ch_en=2'b01, grant_id=0.
- ch_req=2'b11 held continuously, each owner ending after 5 cycles → grants alternate ch0, ch1, ch0, with one NOP cycle between each.
- Granted ch0 with ch_oe=1 and ch_wdata=16'hA5A5 → dq_oe=1, dq_out=A5A5. A ch_end[1] pulse during this grant is ignored and the state stays CHAN.
- TIMEOUT=8, granted channel never ends → timeout_err pulses in the 8th CHAN cycle, next cycle is ARBIT, and the next grant goes to the other channel.
- rst_n pulsed low mid-CHAN → ch_en=0, dq_oe=0, state=INIT asynchronously, and re-init works normally.
